// File: rtl/serial_nibble_sub_ctrl.sv
// Nibble-serial subtractor: one 4-bit borrow-lookahead slice reused LSB-first over NIBBLES cycles.
// Define SERIAL_SUB_SAT_EN to clamp Diff to zero whenever the final borrow is set.

module NibbleBorrowLookahead (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_bin,
    output logic [3:0] o_diff,
    output logic       o_bout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_b;

    // A bit generates a borrow when x<y, and passes one through when x==y.
    assign w_g = ~i_x & i_y;
    assign w_p = ~(i_x ^ i_y);

    assign w_b[0] = i_bin;
    assign w_b[1] = w_g[0] | (w_p[0] & i_bin);
    assign w_b[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_bin);
    assign w_b[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_bin);
    assign o_bout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_bin);

    assign o_diff = i_x ^ i_y ^ w_b;

endmodule

module serial_nibble_sub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] X,
    input  logic [4*NIBBLES-1:0] Y,
    input  logic                 Bin,
    output logic [4*NIBBLES-1:0] Diff,
    output logic                 Bout,
    output logic                 zero,
    output logic                 busy,
    output logic                 done
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [W-1:0]   r_x;
    logic [W-1:0]   r_y;
    logic [W-1:0]   r_res;
    logic [W-1:0]   r_diff;
    logic           r_bout;
    logic           r_borrow;
    logic [IW-1:0]  r_idx;

    logic [3:0]     w_xNib;
    logic [3:0]     w_yNib;
    logic [3:0]     w_sliceDiff;
    logic           w_sliceBout;
    logic [W-1:0]   w_resNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == LAST) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Select the active nibble of the latched operands and merge the slice output back.
    always_comb begin
        w_xNib    = 4'd0;
        w_yNib    = 4'd0;
        w_resNext = r_res;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) begin
                w_xNib                = r_x[n*4 +: 4];
                w_yNib                = r_y[n*4 +: 4];
                w_resNext[n*4 +: 4]   = w_sliceDiff;
            end
        end
    end

    NibbleBorrowLookahead u_slice (
        .i_x    (w_xNib),
        .i_y    (w_yNib),
        .i_bin  (r_borrow),
        .o_diff (w_sliceDiff),
        .o_bout (w_sliceBout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x      <= X;
                        r_y      <= Y;
                        r_borrow <= Bin;
                        r_idx    <= '0;
                    end
                end
                RUN: begin
                    r_res    <= w_resNext;
                    r_borrow <= w_sliceBout;
                    r_idx    <= r_idx + 1'b1;
                    // Only the final nibble publishes, so Diff never shows a partial word.
                    if (r_idx == LAST) begin
                        r_bout <= w_sliceBout;
`ifdef SERIAL_SUB_SAT_EN
                        r_diff <= w_sliceBout ? '0 : w_resNext;
`else
                        r_diff <= w_resNext;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;
    assign zero = (r_diff == '0);

endmodule

// File: tb/tb_serial_nibble_sub_ctrl.sv
// Scoreboard bench for serial_nibble_sub_ctrl (NIBBLES=4); expectations come from a 17-bit arithmetic model.
`timescale 1ns/1ps

module tb_serial_nibble_sub_ctrl;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic        Bin;
    logic [15:0] Diff;
    logic        Bout;
    logic        zero;
    logic        busy;
    logic        done;

    int   totalChecks = 0;
    int   badChecks   = 0;
    exp_t expQ[$];

    serial_nibble_sub_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .Diff  (Diff),
        .Bout  (Bout),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic b);
        exp_t        e;
        logic [16:0] full;
        full   = {1'b0, x} - {1'b0, y} - {16'd0, b};
        e.diff = full[15:0];
        e.bout = full[16];
`ifdef SERIAL_SUB_SAT_EN
        if (e.bout) e.diff = 16'h0000;
`endif
        e.zero = (e.diff == 16'h0000);
        return e;
    endfunction

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic b);
        @(negedge clk);
        X     = x;
        Y     = y;
        Bin   = b;
        start = 1'b1;
        expQ.push_back(model(x, y, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Every done pulse retires the oldest expected result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("diff", {16'd0, Diff}, {16'd0, e.diff});
                checkOutput("bout", {31'd0, Bout}, {31'd0, e.bout});
                checkOutput("zero", {31'd0, zero}, {31'd0, e.zero});
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        X     = 16'h0;
        Y     = 16'h0;
        Bin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_diff", {16'd0, Diff}, 32'h0);
        checkOutput("rst_bout", {31'd0, Bout}, 32'd0);
        checkOutput("rst_zero", {31'd0, zero}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);

        // Basic subtraction with cycle-accurate busy/done timing.
        applyStimulus(16'h1234, 16'h0111, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("basic_busy_T%0d", k), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("basic_done_T%0d", k), {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        checkOutput("basic_done_T5", {31'd0, done}, 32'd1);
        checkOutput("basic_busy_T5", {31'd0, busy}, 32'd0);
        checkOutput("basic_diff_const", {16'd0, Diff}, 32'h1123);

        // Full wrap-around.
        applyStimulus(16'h0000, 16'h0000, 1'b1);
        waitDone("wrap");

        // Start held high; operand changes during RUN must not affect the first result.
        @(negedge clk);
        X     = 16'h8000;
        Y     = 16'h8000;
        Bin   = 1'b0;
        start = 1'b1;
        expQ.push_back(model(16'h8000, 16'h8000, 1'b0));
        @(posedge clk);
        @(negedge clk);
        X   = 16'h1111;
        Y   = 16'h2222;
        Bin = 1'b1;
        expQ.push_back(model(16'h1111, 16'h2222, 1'b1));
        checkOutput("hold_busy_T1", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("hold_busy_T4", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("hold_done_T5", {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("hold_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("hold_idle_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkOutput("hold_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        waitDone("hold2");

        // Reset in the second RUN cycle aborts with no done pulse.
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        void'(expQ.pop_back());
        #1;
        checkOutput("abort_diff", {16'd0, Diff}, 32'h0);
        checkOutput("abort_bout", {31'd0, Bout}, 32'd0);
        checkOutput("abort_zero", {31'd0, zero}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        end
        applyStimulus(16'h00F0, 16'h000F, 1'b0);
        waitDone("after_abort");

        // A few random transactions.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            waitDone("rand");
        end

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
